// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
// Optional CRC16 append is enabled by defining USB_TX_CRC16_EN.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  localparam logic [7:0]  SYNC_BYTE    = 8'h80;
  localparam logic [2:0]  STUFF_LIMIT  = 3'd6;
  localparam int          EOP_SE0_BITS = 2;
  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  // {D+, D-}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and strobes on the last count.
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic restart,
  output logic bit_strobe
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                    cnt <= '0;
    else if (restart || bit_strobe) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  assign bit_strobe = (cnt == LAST);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB FS transmit line encoder: SYNC, LSB-first serialiser, bit stuffing, NRZI, EOP.
// Define USB_TX_CRC16_EN to append the data CRC16 to multi-byte packets.
//   state   | meaning
//   IDLE    | lines at J, waiting for the first byte
//   SYNC    | sending the 8 SYNC bits
//   DATA    | sending the held byte, LSB first
//   STUFF   | inserted 0 after six ones
//   EOP_SE0 | both lines low for two bit times
//   EOP_J   | final J bit time before returning to idle
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       dplus_out,
  output logic       dminus_out
);

  tx_state_t  state, state_n;
  logic [7:0] shreg, shreg_n, load_byte;
  logic [2:0] idx, idx_n;
  logic [2:0] ones, ones_n, ones_base;
  logic [1:0] se0_cnt, se0_n;
  logic [1:0] line, line_n;
  logic       last_q, last_n, to_eop, to_eop_n;
  logic       lvl, lvl_n, lvl_base;
  logic       done_q, done_n, err_q, err_n;
  logic       live, ready, restart, bit_strobe;
  logic       emit, emit_bit, data_emit, load, finish;

`ifdef USB_TX_CRC16_EN
  localparam logic [15:0] CRC_POLY_REF = reflect16(CRC16_POLY);
  logic [15:0] crc, crc_n;
  logic [7:0]  crc_hi, crc_hi_n;
  logic [1:0]  phase, phase_n;
  logic        multi, multi_n;
`endif

  usb_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .restart    (restart),
    .bit_strobe (bit_strobe)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      ones    <= '0;
      se0_cnt <= '0;
      line    <= LINE_J;
      last_q  <= 1'b0;
      to_eop  <= 1'b0;
      lvl     <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      live    <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc     <= CRC16_INIT;
      crc_hi  <= '0;
      phase   <= '0;
      multi   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      idx     <= idx_n;
      ones    <= ones_n;
      se0_cnt <= se0_n;
      line    <= line_n;
      last_q  <= last_n;
      to_eop  <= to_eop_n;
      lvl     <= lvl_n;
      done_q  <= done_n;
      err_q   <= err_n;
      live    <= 1'b1;
`ifdef USB_TX_CRC16_EN
      crc     <= crc_n;
      crc_hi  <= crc_hi_n;
      phase   <= phase_n;
      multi   <= multi_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    idx_n     = idx;
    ones_n    = ones;
    se0_n     = se0_cnt;
    line_n    = line;
    last_n    = last_q;
    to_eop_n  = to_eop;
    lvl_n     = lvl;
    done_n    = 1'b0;
    err_n     = 1'b0;
    ready     = 1'b0;
    restart   = 1'b0;
    emit      = 1'b0;
    emit_bit  = 1'b0;
    data_emit = 1'b0;
    load      = 1'b0;
    load_byte = '0;
    finish    = 1'b0;
    ones_base = ones;
    lvl_base  = lvl;
`ifdef USB_TX_CRC16_EN
    crc_n     = crc;
    crc_hi_n  = crc_hi;
    phase_n   = phase;
    multi_n   = multi;
`endif

    case (state)
      IDLE: begin
        ready = live;
        if (tx_valid && live) begin
          restart   = 1'b1;
          shreg_n   = tx_data;
          last_n    = tx_last;
          idx_n     = '0;
          ones_base = '0;
          lvl_base  = 1'b1;
          state_n   = SYNC;
          emit      = 1'b1;
          emit_bit  = SYNC_BYTE[0];
`ifdef USB_TX_CRC16_EN
          crc_n     = CRC16_INIT;
          phase_n   = '0;
          multi_n   = 1'b0;
`endif
        end
      end
      SYNC: begin
        if (bit_strobe) begin
          emit = 1'b1;
          if (idx == 3'd7) begin
            state_n   = DATA;
            idx_n     = '0;
            emit_bit  = shreg[0];
            data_emit = 1'b1;
          end else begin
            idx_n    = idx + 3'd1;
            emit_bit = SYNC_BYTE[idx + 3'd1];
          end
        end
      end
      DATA: begin
        if (bit_strobe) begin
          if (idx == 3'd7) begin
            if (last_q) begin
`ifdef USB_TX_CRC16_EN
              if (multi && phase == 2'd0) begin
                load      = 1'b1;
                load_byte = ~crc[7:0];
                crc_hi_n  = ~crc[15:8];
                phase_n   = 2'd1;
              end else if (phase == 2'd1) begin
                load      = 1'b1;
                load_byte = crc_hi;
                phase_n   = 2'd2;
              end else begin
                finish = 1'b1;
              end
`else
              finish = 1'b1;
`endif
            end else begin
              ready = 1'b1;
              if (tx_valid) begin
                load      = 1'b1;
                load_byte = tx_data;
                last_n    = tx_last;
`ifdef USB_TX_CRC16_EN
                multi_n   = 1'b1;
`endif
              end else begin
                err_n  = 1'b1;
                finish = 1'b1;
              end
            end
          end else begin
            shreg_n = shreg >> 1;
            idx_n   = idx + 3'd1;
            emit    = 1'b1;
            if (ones == STUFF_LIMIT) begin
              state_n  = STUFF;
              to_eop_n = 1'b0;
            end else begin
              emit_bit  = shreg[1];
              data_emit = 1'b1;
            end
          end
        end
      end
      STUFF: begin
        if (bit_strobe) begin
          if (to_eop) begin
            state_n = EOP_SE0;
            se0_n   = '0;
            line_n  = LINE_SE0;
          end else begin
            state_n   = DATA;
            emit      = 1'b1;
            emit_bit  = shreg[0];
            data_emit = 1'b1;
          end
        end
      end
      EOP_SE0: begin
        if (bit_strobe) begin
          if (se0_cnt == 2'(EOP_SE0_BITS - 1)) begin
            state_n = EOP_J;
            line_n  = LINE_J;
            lvl_n   = 1'b1;
          end else begin
            se0_n = se0_cnt + 2'd1;
          end
        end
      end
      EOP_J: begin
        if (bit_strobe) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A pending run of six ones always takes precedence over the next byte or EOP.
    if (load) begin
      shreg_n = load_byte;
      idx_n   = '0;
      emit    = 1'b1;
      if (ones == STUFF_LIMIT) begin
        state_n  = STUFF;
        to_eop_n = 1'b0;
      end else begin
        state_n   = DATA;
        emit_bit  = load_byte[0];
        data_emit = 1'b1;
      end
    end
    if (finish) begin
      if (ones == STUFF_LIMIT) begin
        state_n  = STUFF;
        to_eop_n = 1'b1;
        emit     = 1'b1;
      end else begin
        state_n = EOP_SE0;
        se0_n   = '0;
        line_n  = LINE_SE0;
      end
    end

    if (emit) begin
      lvl_n  = emit_bit ? lvl_base : ~lvl_base;
      ones_n = emit_bit ? ones_base + 3'd1 : 3'd0;
      line_n = lvl_n ? LINE_J : LINE_K;
    end

`ifdef USB_TX_CRC16_EN
    if (data_emit && multi_n && phase_n == 2'd0)
      crc_n = (crc >> 1) ^ ((crc[0] ^ emit_bit) ? CRC_POLY_REF : 16'h0000);
`endif
  end

  assign tx_ready   = ready;
  assign tx_busy    = (state != IDLE);
  assign tx_done    = done_q;
  assign tx_error   = err_q;
  assign dplus_out  = line[1];
  assign dminus_out = line[0];

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Randomized self-checking bench for usb_tx_encoder against a bit-list reference model.
module tb_usb_tx_encoder;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error, dplus_out, dminus_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pkt[$];
  int         underrun_at;
  logic [1:0] cap_line[$];
  bit         cap_busy[$];
  logic [1:0] exp_sym[$];
  int         done_cnt, err_cnt, ready_cnt;
  bit         timed_out;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .dplus_out  (dplus_out),
    .dminus_out (dminus_out)
  );

  always #5 clk = ~clk;

  // Reference: SYNC + sent bytes as a bit list, stuff after six ones, NRZI from J, then EOP.
  task automatic build_model(input int nsent);
    bit raw[$];
    bit stf[$];
    int run;
    logic lvl;
    logic [7:0] sync_b;
    sync_b = 8'h80;
    raw.delete(); stf.delete(); exp_sym.delete();
    for (int i = 0; i < 8; i++) raw.push_back(sync_b[i]);
    for (int b = 0; b < nsent; b++)
      for (int i = 0; i < 8; i++) raw.push_back(pkt[b][i]);
    run = 0;
    foreach (raw[i]) begin
      stf.push_back(raw[i]);
      run = raw[i] ? run + 1 : 0;
      if (run == 6) begin stf.push_back(1'b0); run = 0; end
    end
    lvl = 1'b1;
    foreach (stf[i]) begin
      if (!stf[i]) lvl = ~lvl;
      exp_sym.push_back(lvl ? 2'b10 : 2'b01);
    end
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b10);
  endtask

  task automatic run_packet();
    int  idx = 0;
    int  cyc = 0;
    int  post = -1;
    bit  acc;
    cap_line.delete(); cap_busy.delete();
    done_cnt = 0; err_cnt = 0; ready_cnt = 0; timed_out = 0;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = pkt[0];
    tx_last  = (pkt.size() == 1);
    forever begin
      @(negedge clk);
      cap_line.push_back({dplus_out, dminus_out});
      cap_busy.push_back(tx_busy);
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_busy && tx_ready) ready_cnt++;
      acc = tx_valid && tx_ready;
      if (tx_done && post < 0) post = 2;
      if (post == 0) break;
      if (post > 0) post--;
      cyc++;
      if (cyc > 4000) begin timed_out = 1; break; end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < pkt.size() && idx != underrun_at) begin
          tx_data = pkt[idx];
          tx_last = (idx == pkt.size() - 1);
        end else begin
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
          tx_last  = 1'b0;
        end
      end
    end
    tx_valid = 1'b0;
  endtask

  function automatic int first_busy();
    foreach (cap_busy[i]) if (cap_busy[i]) return i;
    return 0;
  endfunction

  function automatic int busy_cycles();
    int n = 0;
    foreach (cap_busy[i]) if (cap_busy[i]) n++;
    return n;
  endfunction

  // Line level over one bit time, or X when it does not hold steady for all CPB cycles.
  function automatic logic [1:0] bit_line(input int st, input int k);
    logic [1:0] v;
    if (st + (k + 1) * CPB > cap_line.size()) return 2'bxx;
    v = cap_line[st + k * CPB];
    for (int j = 1; j < CPB; j++)
      if (cap_line[st + k * CPB + j] !== v) return 2'bxx;
    return v;
  endfunction

  function automatic logic [7:0] rnd_byte();
    return ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
  endfunction

  task automatic test_reset();
    n_checks++;
    if ({dplus_out, dminus_out} !== 2'b10) begin
      n_fail++; $display("FAIL reset_lines got %b want 10", {dplus_out, dminus_out});
    end
    n_checks++;
    if ({tx_ready, tx_busy, tx_done, tx_error} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {tx_ready, tx_busy, tx_done, tx_error});
    end
  endtask

  task automatic test_ack();
    int st;
    pkt = '{8'hD2}; underrun_at = -1;
    run_packet(); build_model(1);
    st = first_busy();
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL ack_timeout got timeout want done"); end
    foreach (exp_sym[k]) begin
      n_checks++;
      if (bit_line(st, k) !== exp_sym[k]) begin
        n_fail++; $display("FAIL ack_line bit %0d got %b want %b", k, bit_line(st, k), exp_sym[k]);
      end
    end
    n_checks++;
    if (busy_cycles() != 152) begin n_fail++; $display("FAIL ack_busy got %0d want 152", busy_cycles()); end
    n_checks++;
    if (done_cnt != 1 || err_cnt != 0) begin
      n_fail++; $display("FAIL ack_pulses got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_stuffing();
    logic [7:0] vals[2];
    int st;
    vals[0] = 8'hFF; vals[1] = 8'hFC;
    for (int v = 0; v < 2; v++) begin
      pkt = '{vals[v]}; underrun_at = -1;
      run_packet(); build_model(1);
      st = first_busy();
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL stuff_timeout byte %h", vals[v]); end
      foreach (exp_sym[k]) begin
        n_checks++;
        if (bit_line(st, k) !== exp_sym[k]) begin
          n_fail++; $display("FAIL stuff_line byte %h bit %0d got %b want %b", vals[v], k, bit_line(st, k), exp_sym[k]);
        end
      end
      n_checks++;
      if (busy_cycles() != exp_sym.size() * CPB) begin
        n_fail++; $display("FAIL stuff_busy byte %h got %0d want %0d", vals[v], busy_cycles(), exp_sym.size() * CPB);
      end
    end
    n_checks++;
    if (exp_sym.size() * CPB != 160 && busy_cycles() != 160) begin
      n_fail++; $display("FAIL stuff_len got %0d want 160", busy_cycles());
    end
  endtask

  task automatic test_back_to_back();
    int st, n;
    for (int t = 0; t < 6; t++) begin
      pkt.delete();
      if (t == 0) pkt = '{8'hC3, 8'h01};
      else begin
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) pkt.push_back(rnd_byte());
      end
      underrun_at = -1;
      run_packet(); build_model(pkt.size());
      st = first_busy();
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL b2b_timeout pkt %0d", t); end
      foreach (exp_sym[k]) begin
        n_checks++;
        if (bit_line(st, k) !== exp_sym[k]) begin
          n_fail++; $display("FAIL b2b_line pkt %0d bit %0d got %b want %b", t, k, bit_line(st, k), exp_sym[k]);
        end
      end
      n_checks++;
      if (busy_cycles() != exp_sym.size() * CPB) begin
        n_fail++; $display("FAIL b2b_busy pkt %0d got %0d want %0d", t, busy_cycles(), exp_sym.size() * CPB);
      end
      n_checks++;
      if (ready_cnt != pkt.size() - 1) begin
        n_fail++; $display("FAIL b2b_ready pkt %0d got %0d want %0d", t, ready_cnt, pkt.size() - 1);
      end
      n_checks++;
      if (done_cnt != 1 || err_cnt != 0) begin
        n_fail++; $display("FAIL b2b_pulses pkt %0d got done=%0d err=%0d want 1/0", t, done_cnt, err_cnt);
      end
    end
  endtask

  task automatic test_underrun();
    int st, n;
    for (int t = 0; t < 4; t++) begin
      pkt.delete();
      n = (t == 0) ? 2 : $urandom_range(3, 4);
      for (int i = 0; i < n; i++) pkt.push_back(rnd_byte());
      underrun_at = (t == 0) ? 1 : $urandom_range(1, n - 1);
      run_packet(); build_model(underrun_at);
      st = first_busy();
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL urun_timeout pkt %0d", t); end
      foreach (exp_sym[k]) begin
        n_checks++;
        if (bit_line(st, k) !== exp_sym[k]) begin
          n_fail++; $display("FAIL urun_line pkt %0d bit %0d got %b want %b", t, k, bit_line(st, k), exp_sym[k]);
        end
      end
      n_checks++;
      if (busy_cycles() != exp_sym.size() * CPB) begin
        n_fail++; $display("FAIL urun_busy pkt %0d got %0d want %0d", t, busy_cycles(), exp_sym.size() * CPB);
      end
      n_checks++;
      if (err_cnt != 1 || done_cnt != 1 || ready_cnt != underrun_at) begin
        n_fail++; $display("FAIL urun_pulses pkt %0d got err=%0d done=%0d rdy=%0d want 1/1/%0d",
                           t, err_cnt, done_cnt, ready_cnt, underrun_at);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int st;
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = 8'h5A; tx_last = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    #3;
    n_checks++;
    if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got %b want 1", tx_busy); end
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({dplus_out, dminus_out, tx_busy} !== 3'b100) begin
      n_fail++; $display("FAIL rst_async got %b want 100", {dplus_out, dminus_out, tx_busy});
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    pkt = '{rnd_byte()}; underrun_at = -1;
    run_packet(); build_model(1);
    st = first_busy();
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL rst_timeout got timeout want done"); end
    foreach (exp_sym[k]) begin
      n_checks++;
      if (bit_line(st, k) !== exp_sym[k]) begin
        n_fail++; $display("FAIL rst_line bit %0d got %b want %b", k, bit_line(st, k), exp_sym[k]);
      end
    end
    n_checks++;
    if (done_cnt != 1 || err_cnt != 0) begin
      n_fail++; $display("FAIL rst_pulses got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    test_ack();
    test_stuffing();
    test_back_to_back();
    test_underrun();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
